// File: rtl/hud_pkg.sv
// Shared definitions for the HUD text scheduler: FSM states, string windows,
// character-code tables and the per-character code lookup.
package hud_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, FETCH} state_e;
    typedef enum logic [1:0] {STR_NONE, STR_LIVES, STR_SCORE, STR_GOVER} str_e;

    localparam int NCHAR_MAX = 9;
    localparam logic [9:0] GLYPH_H = 10'd16;

    localparam logic [9:0] LIVES_X0 = 10'd456;
    localparam logic [9:0] LIVES_Y0 = 10'd96;
    localparam logic [9:0] SCORE_X0 = 10'd456;
    localparam logic [9:0] SCORE_Y0 = 10'd120;
    localparam logic [9:0] GOVER_X0 = 10'd296;
    localparam logic [9:0] GOVER_Y0 = 10'd240;

    localparam logic [3:0] LIVES_LEN = 4'd8;
    localparam logic [3:0] SCORE_LEN = 4'd7;
    localparam logic [3:0] GOVER_LEN = 4'd9;

    // Every glyph code is below 0x80, so 7 bits plus a 4-bit row fill font_addr.
    localparam logic [0:7][6:0] LIVES_CODES =
        {7'h6C, 7'h69, 7'h76, 7'h65, 7'h73, 7'h3A, 7'h00, 7'h30};
    localparam logic [0:6][6:0] SCORE_CODES =
        {7'h16, 7'h3A, 7'h00, 7'h30, 7'h30, 7'h30, 7'h30};
    localparam logic [0:8][6:0] GOVER_CODES =
        {7'h67, 7'h61, 7'h6D, 7'h65, 7'h00, 7'h6F, 7'h76, 7'h65, 7'h72};

    function automatic logic [9:0] str_x0(str_e s);
        case (s)
            STR_LIVES: return LIVES_X0;
            STR_SCORE: return SCORE_X0;
            STR_GOVER: return GOVER_X0;
            default:   return 10'd0;
        endcase
    endfunction

    function automatic logic [3:0] str_len(str_e s);
        case (s)
            STR_LIVES: return LIVES_LEN;
            STR_SCORE: return SCORE_LEN;
            STR_GOVER: return GOVER_LEN;
            default:   return 4'd0;
        endcase
    endfunction

    // Digit slots hold '0' (0x30), so OR-ing in a 0..9 value yields its ASCII glyph.
    function automatic logic [6:0] char_code(str_e s, logic [3:0] i, logic [1:0] lv,
                                             logic [15:0] bcd);
        logic [6:0] c;
        logic [3:0] d;
        c = '0;
        case (i)
            4'd3:    d = bcd[15:12];
            4'd4:    d = bcd[11:8];
            4'd5:    d = bcd[7:4];
            4'd6:    d = bcd[3:0];
            default: d = 4'd0;
        endcase
        case (s)
            STR_LIVES: c = LIVES_CODES[i[2:0]] | ((i == 4'd7) ? {5'd0, lv} : 7'd0);
            STR_SCORE: if (i < SCORE_LEN) c = SCORE_CODES[i[2:0]] | {3'd0, d};
            STR_GOVER: if (i < GOVER_LEN) c = GOVER_CODES[i];
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: 11-bit binary to four BCD digits, one shift-add-3
// iteration per clock after start; done holds for one cycle once all 11 are in.
module bcd_converter (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic [10:0]     bin,
    output logic            done,
    output logic [3:0][3:0] bcd
);

    logic [26:0] sh, adj;
    logic [3:0]  cnt;
    logic        active;

    always_comb begin
        adj = sh;
        for (int d = 0; d < 4; d++) begin
            if (adj[11+4*d +: 4] >= 4'd5)
                adj[11+4*d +: 4] = adj[11+4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh     <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            sh     <= {16'd0, bin};
            cnt    <= 4'd11;
            active <= 1'b1;
        end else if (active) begin
            if (cnt != 4'd0) begin
                sh  <= adj << 1;
                cnt <= cnt - 4'd1;
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign done = active && (cnt == 4'd0);
    assign bcd  = sh[26:11];

endmodule

// File: rtl/hud_text_scheduler.sv
// HUD text scheduler: converts the score once per frame and, during hblank,
// prefetches one glyph row per character of the string on the next line.
module hud_text_scheduler
    import hud_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        death,
    input  logic [10:0] score,
    input  logic [1:0]  lives,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        text_on,
    output logic [1:0]  text_sel,
    output logic        busy
);

    state_e state, state_nx;
    str_e   hit_str, f_str, buf_str;
    logic [9:0]  tgt_y, f_tgt, buf_tag, col;
    logic [3:0]  row_c, f_row, idx;
    logic [1:0]  f_lives;
    logic        conv_start, conv_done, fetch_go, buf_valid, pix_on;
    logic [3:0][3:0] conv_bcd, digits;
    logic [NCHAR_MAX-1:0][7:0] line_buf;

    assign tgt_y = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;

    // Windows never overlap vertically; row offset only needs the low 4 bits.
    always_comb begin
        hit_str = STR_NONE;
        row_c   = 4'd0;
        if (!death && tgt_y >= LIVES_Y0 && tgt_y < LIVES_Y0 + GLYPH_H) begin
            hit_str = STR_LIVES;
            row_c   = tgt_y[3:0] - LIVES_Y0[3:0];
        end else if (tgt_y >= SCORE_Y0 && tgt_y < SCORE_Y0 + GLYPH_H) begin
            hit_str = STR_SCORE;
            row_c   = tgt_y[3:0] - SCORE_Y0[3:0];
        end else if (death && tgt_y >= GOVER_Y0 && tgt_y < GOVER_Y0 + GLYPH_H) begin
            hit_str = STR_GOVER;
            row_c   = tgt_y[3:0] - GOVER_Y0[3:0];
        end
    end

    bcd_converter u_bcd (
        .Clk   (Clk),
        .Reset (Reset),
        .start (conv_start),
        .bin   (score),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        conv_start = 1'b0;
        case (state)
            IDLE: begin
                if (DrawX == 10'd0 && DrawY == 10'd480) begin
                    state_nx   = CONVERT;
                    conv_start = 1'b1;
                end else if (DrawX == 10'd640 && hit_str != STR_NONE) begin
                    state_nx = FETCH;
                end
            end
            CONVERT: if (conv_done) state_nx = IDLE;
            FETCH:   if (idx == str_len(f_str)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign fetch_go = (state == IDLE) && (state_nx == FETCH);
    assign busy     = (state != IDLE);

    always_comb begin
        font_addr = '0;
        if (state == FETCH && idx < str_len(f_str))
            font_addr = {char_code(f_str, idx, f_lives, digits), f_row};
    end

    // ROM data trails its address by a cycle, so entry idx-1 lands while idx is issued.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx       <= '0;
            f_str     <= STR_NONE;
            f_row     <= '0;
            f_lives   <= '0;
            f_tgt     <= '0;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_str   <= STR_NONE;
            line_buf  <= '0;
            digits    <= '0;
        end else begin
            if (fetch_go) begin
                idx       <= '0;
                f_str     <= hit_str;
                f_row     <= row_c;
                f_lives   <= lives;
                f_tgt     <= tgt_y;
                buf_valid <= 1'b0;
            end
            if (state == FETCH) begin
                idx <= idx + 4'd1;
                if (idx != 4'd0) line_buf[idx - 4'd1] <= font_data;
                if (idx == str_len(f_str)) begin
                    buf_valid <= 1'b1;
                    buf_tag   <= f_tgt;
                    buf_str   <= f_str;
                end
            end
            if (state == CONVERT && conv_done) digits <= conv_bcd;
        end
    end

    // Unsigned wrap makes any DrawX left of the window compare as out of range.
    always_comb begin
        col    = DrawX - str_x0(buf_str);
        pix_on = buf_valid && (DrawY == buf_tag)
              && (col < {3'd0, str_len(buf_str), 3'd0})
              && line_buf[col[6:3]][~col[2:0]];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            text_on  <= 1'b0;
            text_sel <= 2'd0;
        end else begin
            text_on  <= pix_on;
            text_sel <= !pix_on ? 2'd0 : (buf_str == STR_GOVER) ? 2'd2 : 2'd1;
        end
    end

endmodule

// File: doc/hud_text_scheduler.md
HUD_TEXT_SCHEDULER -- requirements
Module: hud_text_scheduler

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port DrawX, input, 10, current VGA pixel column (0..799; active 0..639); advances at most once per Clk.
REQ-004 SHALL have port DrawY, input, 10, current VGA line (0..524; active 0..479).
REQ-005 SHALL have port death, input, 1, game-over flag.
REQ-006 SHALL have port score, input, 11, current score (0..2047).
REQ-007 SHALL have port lives, input, 2, lives remaining.
REQ-008 SHALL have port font_addr, output, 11, address to the single shared font_rom (char*16 + row).
REQ-009 SHALL have port font_data, input, 8, font_rom row data, valid exactly 1 Clk after font_addr.
REQ-010 SHALL have port text_on, output, 1, current pixel is a lit HUD glyph pixel.
REQ-011 SHALL have port text_sel, output, 2, colour class: 0 none, 1 white (LIVES/SCORE), 2 yellow (GAME OVER).
REQ-012 SHALL have port busy, output, 1, high when FSM not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CONVERT, FETCH.
REQ-014 SHALL go IDLE->CONVERT when DrawX==0 && DrawY==480; snapshot score at entry.
REQ-015 SHALL, in CONVERT, run 11 shift-add-3 (double-dabble) iterations, 1 per Clk, then commit 4 BCD digits atomically and return to IDLE (12 Clk total).
REQ-016 SHALL go IDLE->FETCH when DrawX==640, for target line T = (DrawY==524) ? 0 : DrawY+1, only if T hits a visible string.
REQ-017 SHALL use string windows: LIVES y 96..111, x 456..519, 8 chars, shown only when death==0; SCORE y 120..135, x 456..511, 7 chars, always shown; GAME OVER y 240..255, x 296..367, 9 chars, shown only when death==1.
REQ-018 SHALL use char codes LIVES: 6C 69 76 65 73 3A 00 (30+lives); SCORE: 16 3A 00 (30+d3) (30+d2) (30+d1) (30+d0); GAME OVER: 67 61 6D 65 00 6F 76 65 72.
REQ-019 SHALL, in FETCH, issue font_addr = code[i]*16 + (T - window_top) for i = 0..N-1 on consecutive Clks and write font_data into line buffer entry i one Clk later; N+1 Clk total, then IDLE.
REQ-020 SHALL set buffer tag = T and buffer_valid = 1 on FETCH completion; buffer_valid = 0 at FETCH entry.
REQ-021 SHALL drive text_on = 1 only when buffer_valid, DrawY == tag, DrawX inside the active window, and buffer[(DrawX-x0)>>3][7-((DrawX-x0)%8)] == 1; otherwise text_on = 0 and text_sel = 0.
REQ-022 SHALL register text_on/text_sel (1-Clk latency from DrawX/DrawY).
REQ-023 SHALL ignore a FETCH trigger when not IDLE; buffer_valid stays 0 and that line shows no text.
REQ-024 SHALL hold font_addr = 0 when not in FETCH.
REQ-025 SHALL sample death and lives at FETCH entry; changes mid-line take effect on the next fetched line.

Reset
REQ-026 SHALL, on Reset, force state IDLE, font_addr 0, text_on 0, text_sel 0, busy 0, buffer_valid 0, buffer entries 0, BCD digits 0, tag 0.
REQ-027 SHALL honour Reset mid-CONVERT or mid-FETCH, abandoning partial results (digits remain 0).

Structure
REQ-028 SHALL place state enum, window coordinates, char-code tables and string lengths in shared package hud_pkg.
REQ-029 SHALL implement the double-dabble as sub-module bcd_converter (start, 11-bit in, done, 4x4-bit out).

Verification
REQ-030 Reset asserted mid-FETCH -> next Clk text_on=0, busy=0, font_addr=0.
REQ-031 score=1234, frame start (DrawY=480, DrawX=0) -> digits 1,2,3,4 after 12 Clk; line 125 fetch addresses include 0x31*16+5 = 0x315.
REQ-032 death=0, lives=3, DrawY=99, DrawX=640 -> 8 fetches; last address 0x33*16+4 = 0x334; busy high 9 Clk.
REQ-033 death=1, DrawY=239 hblank -> GAME OVER fetch, 9 addresses starting 0x670; on line 240 text_sel=2 at lit pixels in x 296..367; LIVES never fetched.
REQ-034 DrawY=524, DrawX=640 -> target line 0, no string hit, FSM stays IDLE, text_on=0 all of line 0.
REQ-035 score=2047 -> digits 2,0,4,7; score=0 -> all '0' glyphs (code 0x30).
